// File: rtl/cdb_pkg.sv
// Common-data-bus types and ROB age helper shared by the CDB arbiter, reorder buffer and
// reservation stations.
package cdb_pkg;
  localparam int CDB_XLEN    = 32;
  localparam int CDB_TAG_W   = 5;
  localparam int CDB_TAG_MAX = 8;

  typedef struct packed {
    logic                 live;
    logic                 exception;
    logic [CDB_TAG_W-1:0] tag;
    logic [CDB_XLEN-1:0]  value;
  } cdb_entry_t;

  // Distance of a tag from the ROB head, wrapping at 2**tag_w; larger means younger.
  function automatic logic [CDB_TAG_MAX-1:0] rob_age(
    input logic [CDB_TAG_MAX-1:0] tag,
    input logic [CDB_TAG_MAX-1:0] head,
    input int unsigned            tag_w
  );
    logic [CDB_TAG_MAX-1:0] mask;
    mask = (CDB_TAG_MAX'(1) << tag_w) - CDB_TAG_MAX'(1);
    return (tag - head) & mask;
  endfunction
endpackage

// File: rtl/fu_result_fifo.sv
// Per-source result FIFO: holds results until granted a CDB lane, kills entries younger than
// a flushing branch and drains dead heads without using a lane.
module fu_result_fifo
  import cdb_pkg::*;
#(
  parameter int XLEN      = CDB_XLEN,
  parameter int TAG_WIDTH = CDB_TAG_W,
  parameter int DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push_valid,
  input  logic [XLEN-1:0]      push_value,
  input  logic [TAG_WIDTH-1:0] push_tag,
  input  logic                 push_exception,
  output logic                 push_ready,
  input  logic                 flush,
  input  logic [TAG_WIDTH-1:0] flush_tag,
  input  logic [TAG_WIDTH-1:0] rob_head,
  output logic                 head_cand,
  output logic [XLEN-1:0]      head_value,
  output logic [TAG_WIDTH-1:0] head_tag,
  output logic                 head_exception,
  input  logic                 pop_grant
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [DEPTH-1:0]     live_q;
  logic [XLEN-1:0]      value_mem [DEPTH];
  logic [TAG_WIDTH-1:0] tag_mem   [DEPTH];
  logic [DEPTH-1:0]     exc_mem;
  logic                 nonempty, do_push, do_pop;

  function automatic logic killed(
    input logic [TAG_WIDTH-1:0] tag,
    input logic                 fl,
    input logic [TAG_WIDTH-1:0] ftag,
    input logic [TAG_WIDTH-1:0] head
  );
    return fl && (rob_age(CDB_TAG_MAX'(tag), CDB_TAG_MAX'(head), TAG_WIDTH) >
                  rob_age(CDB_TAG_MAX'(ftag), CDB_TAG_MAX'(head), TAG_WIDTH));
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    nonempty       = (count != '0);
    head_value     = value_mem[rd_ptr];
    head_tag       = tag_mem[rd_ptr];
    head_exception = exc_mem[rd_ptr];
    // A head killed by this cycle's flush is already masked from arbitration.
    head_cand      = nonempty && live_q[rd_ptr] &&
                     !killed(tag_mem[rd_ptr], flush, flush_tag, rob_head);
    push_ready     = (count != CNT_W'(DEPTH));
    do_push        = push_valid && push_ready && !killed(push_tag, flush, flush_tag, rob_head);
    do_pop         = nonempty && (pop_grant || !head_cand);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      live_q <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (!do_push && do_pop) count <= count - CNT_W'(1);
      for (int k = 0; k < DEPTH; k++)
        if (killed(tag_mem[k], flush, flush_tag, rob_head)) live_q[k] <= 1'b0;
      if (do_push) live_q[wr_ptr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      value_mem[wr_ptr] <= push_value;
      tag_mem[wr_ptr]   <= push_tag;
      exc_mem[wr_ptr]   <= push_exception;
    end
  end

  drop_chk: assert property (@(posedge clk) disable iff (!reset) !(push_valid && !push_ready))
    else $warning("fu_result_fifo: result tag %0d dropped, FIFO full", push_tag);
endmodule

// File: rtl/cdb_output_arbiter.sv
// CDB front end: per-source result FIFOs feeding a rotating round-robin arbiter that fills
// up to N_CDB broadcast lanes per cycle.
module cdb_output_arbiter
  import cdb_pkg::*;
#(
  parameter int XLEN      = CDB_XLEN,
  parameter int TAG_WIDTH = CDB_TAG_W,
  parameter int N_SRC     = 4,
  parameter int DEPTH     = 2,
  parameter int N_CDB     = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_SRC-1:0]           fu_valid,
  input  logic [N_SRC*XLEN-1:0]      fu_value,
  input  logic [N_SRC*TAG_WIDTH-1:0] fu_tag,
  input  logic [N_SRC-1:0]           fu_exception,
  output logic [N_SRC-1:0]           fu_ready,
  input  logic                       flush,
  input  logic [TAG_WIDTH-1:0]       flush_tag,
  input  logic [TAG_WIDTH-1:0]       rob_head,
  output logic [N_CDB-1:0]           cdb_valid,
  output logic [N_CDB*XLEN-1:0]      cdb_data,
  output logic [N_CDB*TAG_WIDTH-1:0] cdb_rob_tag,
  output logic [N_CDB-1:0]           cdb_exception,
  output logic [N_SRC-1:0]           cdb_grant
);
  localparam int RR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [RR_W-1:0]      rr_ptr, rr_next;
  logic [N_SRC-1:0]     cand;
  logic [XLEN-1:0]      head_value [N_SRC];
  logic [TAG_WIDTH-1:0] head_tag   [N_SRC];
  logic [N_SRC-1:0]     head_exc;
  int                   pos  [N_SRC];
  int                   rank [N_SRC];
  int                   best_pos;

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    fu_result_fifo #(
      .XLEN      (XLEN),
      .TAG_WIDTH (TAG_WIDTH),
      .DEPTH     (DEPTH)
    ) u_fifo (
      .clk            (clk),
      .reset          (reset),
      .push_valid     (fu_valid[i]),
      .push_value     (fu_value[i*XLEN +: XLEN]),
      .push_tag       (fu_tag[i*TAG_WIDTH +: TAG_WIDTH]),
      .push_exception (fu_exception[i]),
      .push_ready     (fu_ready[i]),
      .flush          (flush),
      .flush_tag      (flush_tag),
      .rob_head       (rob_head),
      .head_cand      (cand[i]),
      .head_value     (head_value[i]),
      .head_tag       (head_tag[i]),
      .head_exception (head_exc[i]),
      .pop_grant      (cdb_grant[i])
    );
  end

  // Each candidate's lane is the number of candidates ahead of it in rotated scan order.
  always_comb begin
    cdb_grant     = '0;
    cdb_valid     = '0;
    cdb_data      = '0;
    cdb_rob_tag   = '0;
    cdb_exception = '0;
    rr_next       = rr_ptr;
    best_pos      = -1;
    for (int i = 0; i < N_SRC; i++) begin
      pos[i] = i - int'(rr_ptr);
      if (pos[i] < 0) pos[i] = pos[i] + N_SRC;
    end
    for (int i = 0; i < N_SRC; i++) begin
      rank[i] = 0;
      for (int m = 0; m < N_SRC; m++)
        if (cand[m] && pos[m] < pos[i]) rank[i] = rank[i] + 1;
    end
    for (int i = 0; i < N_SRC; i++) begin
      if (cand[i] && rank[i] < N_CDB) begin
        cdb_grant[i] = 1'b1;
        if (pos[i] > best_pos) begin
          best_pos = pos[i];
          rr_next  = RR_W'((i + 1) % N_SRC);
        end
        for (int j = 0; j < N_CDB; j++) begin
          if (rank[i] == j) begin
            cdb_valid[j]                        = 1'b1;
            cdb_data[j*XLEN +: XLEN]            = head_value[i];
            cdb_rob_tag[j*TAG_WIDTH +: TAG_WIDTH] = head_tag[i];
            cdb_exception[j]                    = head_exc[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rr_ptr <= '0;
    else        rr_ptr <= rr_next;
  end
endmodule

// File: tb/tb_cdb_output_arbiter.sv
// Scoreboard bench: dut_a has one lane and 2-deep FIFOs, dut_b two lanes and 1-deep FIFOs.
module tb_cdb_output_arbiter;
  typedef struct {
    logic [4:0]  tag;
    logic [31:0] data;
    logic        exc;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic [4:0]   flush_tag, rob_head;

  logic [3:0]   fu_valid_a, fu_exc_a, fu_ready_a, cdb_grant_a;
  logic [127:0] fu_value_a;
  logic [19:0]  fu_tag_a;
  logic [0:0]   cdb_valid_a, cdb_exc_a;
  logic [31:0]  cdb_data_a;
  logic [4:0]   cdb_tag_a;

  logic [3:0]   fu_valid_b, fu_exc_b, fu_ready_b, cdb_grant_b;
  logic [127:0] fu_value_b;
  logic [19:0]  fu_tag_b;
  logic [1:0]   cdb_valid_b, cdb_exc_b;
  logic [63:0]  cdb_data_b;
  logic [9:0]   cdb_tag_b;

  exp_t qa[$];
  exp_t qb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  cdb_output_arbiter #(.XLEN(32), .TAG_WIDTH(5), .N_SRC(4), .DEPTH(2), .N_CDB(1)) u_dut_a (
    .clk(clk), .reset(reset), .fu_valid(fu_valid_a), .fu_value(fu_value_a), .fu_tag(fu_tag_a),
    .fu_exception(fu_exc_a), .fu_ready(fu_ready_a), .flush(flush), .flush_tag(flush_tag),
    .rob_head(rob_head), .cdb_valid(cdb_valid_a), .cdb_data(cdb_data_a),
    .cdb_rob_tag(cdb_tag_a), .cdb_exception(cdb_exc_a), .cdb_grant(cdb_grant_a)
  );

  cdb_output_arbiter #(.XLEN(32), .TAG_WIDTH(5), .N_SRC(4), .DEPTH(1), .N_CDB(2)) u_dut_b (
    .clk(clk), .reset(reset), .fu_valid(fu_valid_b), .fu_value(fu_value_b), .fu_tag(fu_tag_b),
    .fu_exception(fu_exc_b), .fu_ready(fu_ready_b), .flush(flush), .flush_tag(flush_tag),
    .rob_head(rob_head), .cdb_valid(cdb_valid_b), .cdb_data(cdb_data_b),
    .cdb_rob_tag(cdb_tag_b), .cdb_exception(cdb_exc_b), .cdb_grant(cdb_grant_b)
  );

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] val_of(input int t);
    return 32'hC0DE_0000 + 32'(t);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    fu_valid_a = '0; fu_exc_a = '0;
    fu_valid_b = '0; fu_exc_b = '0;
  endtask

  task automatic drive_a(input int src, input int t, input logic exc);
    fu_valid_a[src]           = 1'b1;
    fu_tag_a[src*5 +: 5]      = 5'(t);
    fu_value_a[src*32 +: 32]  = val_of(t);
    fu_exc_a[src]             = exc;
  endtask

  task automatic drive_b(input int src, input int t, input logic [31:0] v);
    fu_valid_b[src]           = 1'b1;
    fu_tag_b[src*5 +: 5]      = 5'(t);
    fu_value_b[src*32 +: 32]  = v;
    fu_exc_b[src]             = 1'b0;
  endtask

  task automatic exp_a(input int t, input logic exc);
    qa.push_back('{tag: 5'(t), data: val_of(t), exc: exc});
  endtask

  task automatic exp_b(input int t, input logic [31:0] v);
    qb.push_back('{tag: 5'(t), data: v, exc: 1'b0});
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < bound) begin
      tick();
      n++;
    end
    tick();
    tick();
    check("drain_a", qa.size(), 0);
    check("drain_b", qb.size(), 0);
    qa.delete();
    qb.delete();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      check("a_grant_cnt", $countones(cdb_grant_a), $countones(cdb_valid_a));
      if (cdb_valid_a[0]) begin
        if (qa.size() == 0) check("a_unexpected_tag", cdb_tag_a, 64'hFFFF);
        else begin
          e = qa.pop_front();
          check("a_tag", cdb_tag_a, e.tag);
          check("a_data", cdb_data_a, e.data);
          check("a_exc", cdb_exc_a, e.exc);
        end
      end else check("a_idle_lane", {cdb_data_a, cdb_tag_a, cdb_exc_a}, 0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      check("b_grant_cnt", $countones(cdb_grant_b), $countones(cdb_valid_b));
      if (cdb_valid_b[1]) check("b_lane_order", cdb_valid_b[0], 1);
      for (int j = 0; j < 2; j++) begin
        if (cdb_valid_b[j]) begin
          if (qb.size() == 0) check("b_unexpected_tag", cdb_tag_b[j*5 +: 5], 64'hFFFF);
          else begin
            e = qb.pop_front();
            check("b_tag", cdb_tag_b[j*5 +: 5], e.tag);
            check("b_data", cdb_data_b[j*32 +: 32], e.data);
            check("b_exc", cdb_exc_b[j], e.exc);
          end
        end else check("b_idle_lane", {cdb_data_b[j*32 +: 32], cdb_tag_b[j*5 +: 5], cdb_exc_b[j]}, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected completion within 100000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    flush = 1'b0; flush_tag = '0; rob_head = '0;
    fu_value_a = '0; fu_tag_a = '0; fu_value_b = '0; fu_tag_b = '0;
    idle_in();
    #1 reset = 1'b0;
    #2;
    check("rst_ready_a", fu_ready_a, 4'hF);
    check("rst_valid_a", cdb_valid_a, 0);
    check("rst_grant_a", cdb_grant_a, 0);
    check("rst_ready_b", fu_ready_b, 4'hF);
    check("rst_valid_b", cdb_valid_b, 0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Reset with two entries queued
    drive_a(0, 17, 0); drive_a(1, 18, 0);
    tick(); idle_in();
    check("pre_rst_valid_a", cdb_valid_a, 1);
    reset = 1'b0;
    #1;
    check("midrst_valid_a", cdb_valid_a, 0);
    check("midrst_ready_a", fu_ready_a, 4'hF);
    check("midrst_grant_a", cdb_grant_a, 0);
    tick();
    reset = 1'b1;
    tick();
    check("post_rst_valid_a", cdb_valid_a, 0);

    // Single lane round robin, rotation across bursts
    for (int s = 0; s < 4; s++) begin drive_a(s, s + 1, s == 2); exp_a(s + 1, s == 2); end
    tick(); idle_in(); drain(20);
    for (int s = 0; s < 4; s++) begin drive_a(s, s + 5, 0); exp_a(s + 5, 0); end
    tick(); idle_in(); drain(20);
    drive_a(2, 9, 0); exp_a(9, 0);
    tick(); idle_in(); drain(20);
    for (int s = 0; s < 4; s++) drive_a(s, s + 10, 0);
    exp_a(13, 0); exp_a(10, 0); exp_a(11, 0); exp_a(12, 0);
    tick(); idle_in(); drain(20);

    // Two lanes
    for (int s = 0; s < 4; s++) begin drive_b(s, s + 1, val_of(s + 1)); exp_b(s + 1, val_of(s + 1)); end
    tick(); idle_in(); drain(20);
    for (int s = 0; s < 4; s++) begin drive_b(s, s + 5, val_of(s + 5)); exp_b(s + 5, val_of(s + 5)); end
    tick(); idle_in(); drain(20);
    drive_b(1, 9, val_of(9)); exp_b(9, val_of(9));
    tick(); idle_in(); drain(20);
    drive_b(0, 10, val_of(10)); drive_b(2, 12, val_of(12)); drive_b(3, 13, val_of(13));
    exp_b(12, val_of(12)); exp_b(13, val_of(13)); exp_b(10, val_of(10));
    tick(); idle_in(); drain(20);

    // Backpressure on source 1 of dut_a (rr_ptr moved to 2 first)
    drive_a(1, 14, 0); exp_a(14, 0);
    tick(); idle_in(); drain(20);
    drive_a(0, 20, 0); drive_a(1, 21, 0); drive_a(2, 22, 0); drive_a(3, 23, 0);
    exp_a(22, 0); exp_a(23, 0); exp_a(20, 0); exp_a(21, 0); exp_a(24, 0);
    tick(); idle_in();
    drive_a(1, 24, 0);
    tick(); idle_in();
    check("full_ready1_a", fu_ready_a[1], 0);
    drive_a(1, 25, 0);
    tick(); idle_in();
    check("drop_ready1_a", fu_ready_a[1], 0);
    tick();
    check("granted_ready1_a", fu_ready_a[1], 0);
    check("granted_grant1_a", cdb_grant_a[1], 1);
    tick();
    check("freed_ready1_a", fu_ready_a[1], 1);
    drain(20);

    // Flush around a wrapped ROB head
    rob_head = 5'd30;
    drive_a(2, 31, 0); drive_a(3, 1, 0); drive_a(1, 3, 0);
    exp_a(31, 0); exp_a(1, 0);
    tick(); idle_in();
    flush = 1'b1; flush_tag = 5'd1;
    drive_a(0, 2, 0);
    tick(); idle_in();
    flush = 1'b0;
    drain(20);
    drive_a(1, 7, 0); exp_a(7, 0);
    tick(); idle_in(); drain(20);
    rob_head = '0;

    // Depth-1 FIFO: full with head granted, then refill
    drive_b(0, 9, 32'hA5A5_0001); exp_b(9, 32'hA5A5_0001); exp_b(10, 32'hA5A5_0002);
    tick(); idle_in();
    check("d1_full_ready_b", fu_ready_b[0], 0);
    check("d1_full_grant_b", cdb_grant_b[0], 1);
    tick();
    check("d1_freed_ready_b", fu_ready_b[0], 1);
    drive_b(0, 10, 32'hA5A5_0002);
    tick(); idle_in(); drain(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
